// File: rtl/hub75_pkg.sv
// Shared types, default geometry and helpers for the HUB75 scan controller.
package hub75_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREFETCH,
    ST_SHIFT,
    ST_BLANK,
    ST_LATCH,
    ST_DISPLAY
  } state_t;

  localparam int DEF_COLS     = 64;
  localparam int DEF_ROW_BITS = 5;
  localparam int DEF_BCM_BITS = 3;
  localparam int DEF_BASE_ON  = 8;

  localparam int COL_W        = $clog2(DEF_COLS);
  localparam int PLANE_W      = (DEF_BCM_BITS > 1) ? $clog2(DEF_BCM_BITS) : 1;
  localparam int SHIFT_CYCLES = 2 * DEF_COLS;

  // A single bit-plane still needs a one-bit plane index.
  function automatic int plane_width(input int bcm_bits);
    return (bcm_bits > 1) ? $clog2(bcm_bits) : 1;
  endfunction

  function automatic int on_cycles(input int base_on, input int plane);
    return base_on << plane;
  endfunction

endpackage

// File: rtl/hub75_bcm_timer.sv
// BCM on-time counter for one row-plane; with HUB75_BRIGHTNESS_EN it also gates NOE by a 4-bit pwm.
module hub75_bcm_timer
  import hub75_pkg::*;
#(
  parameter int BCM_BITS = DEF_BCM_BITS,
  parameter int BASE_ON  = DEF_BASE_ON,
  parameter int PW       = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          run,
  input  logic [PW-1:0] plane,
`ifdef HUB75_BRIGHTNESS_EN
  input  logic [3:0]    brightness,
`endif
  output logic          done,
  output logic          on
);

  localparam int CNT_W = $clog2(on_cycles(BASE_ON, BCM_BITS - 1) + 1);

  logic [CNT_W-1:0] cnt_reg;

  // Loaded with N-1 so the display window ends on the cycle the count reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= CNT_W'(on_cycles(BASE_ON, int'(plane)) - 1);
    end else if (run && cnt_reg != '0) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign done = (cnt_reg == '0);

`ifdef HUB75_BRIGHTNESS_EN
  logic [3:0] pwm_reg;
  logic [3:0] bright_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_reg    <= '0;
      bright_reg <= '0;
    end else if (load) begin
      pwm_reg    <= '0;
      bright_reg <= brightness;
    end else if (run) begin
      pwm_reg    <= pwm_reg + 1'b1;
    end
  end

  assign on = (pwm_reg <= bright_reg);
`else
  assign on = 1'b1;
`endif

endmodule

// File: rtl/hub75_scan_ctrl.sv
// HUB75 64x64 1/32-scan sequencer: fetch bit-planes, shift, latch, BCM display per row-plane.
// Define HUB75_BRIGHTNESS_EN to add the brightness[3:0] input that gates NOE with a pwm.
module hub75_scan_ctrl
  import hub75_pkg::*;
#(
  parameter int COLS     = DEF_COLS,
  parameter int ROW_BITS = DEF_ROW_BITS,
  parameter int BCM_BITS = DEF_BCM_BITS,
  parameter int BASE_ON  = DEF_BASE_ON
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
`ifdef HUB75_BRIGHTNESS_EN
  input  logic [3:0]                        brightness,
`endif
  output logic                              fb_rd_en,
  output logic [ROW_BITS-1:0]               fb_row,
  output logic [$clog2(COLS)-1:0]           fb_col,
  output logic [plane_width(BCM_BITS)-1:0]  fb_plane,
  input  logic [5:0]                        fb_rd_data,
  output logic                              LP_CLK,
  output logic                              LATCH,
  output logic                              NOE,
  output logic [ROW_BITS-1:0]               ROW,
  output logic [2:0]                        RGB0,
  output logic [2:0]                        RGB1,
  output logic                              frame_done
);

  localparam int CW = $clog2(COLS);
  localparam int PW = plane_width(BCM_BITS);
  localparam logic [CW-1:0] LAST_COL   = CW'(COLS - 1);
  localparam logic [PW-1:0] LAST_PLANE = PW'(BCM_BITS - 1);

  state_t              state_reg, state_next;
  logic [ROW_BITS-1:0] row_reg, row_next;
  logic [PW-1:0]       plane_reg, plane_next;
  logic [CW-1:0]       col_reg, col_next;
  logic                ph_reg, ph_next;

  logic                rd_en_next, lp_next, latch_next, noe_next, frame_next;
  logic [ROW_BITS-1:0] fb_row_next, row_out_next;
  logic [CW-1:0]       fb_col_next;
  logic [PW-1:0]       fb_plane_next;
  logic [2:0]          rgb0_next, rgb1_next;

  logic                timer_load, timer_done, timer_on, in_display;

  assign in_display = (state_reg == ST_DISPLAY);

  hub75_bcm_timer #(
    .BCM_BITS (BCM_BITS),
    .BASE_ON  (BASE_ON),
    .PW       (PW)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .run        (in_display),
    .plane      (plane_reg),
`ifdef HUB75_BRIGHTNESS_EN
    .brightness (brightness),
`endif
    .done       (timer_done),
    .on         (timer_on)
  );

  always_comb begin
    state_next    = state_reg;
    row_next      = row_reg;
    plane_next    = plane_reg;
    col_next      = col_reg;
    ph_next       = ph_reg;
    timer_load    = 1'b0;
    rd_en_next    = 1'b0;
    fb_row_next   = fb_row;
    fb_col_next   = fb_col;
    fb_plane_next = fb_plane;
    lp_next       = 1'b0;
    latch_next    = 1'b0;
    noe_next      = 1'b1;
    row_out_next  = ROW;
    rgb0_next     = RGB0;
    rgb1_next     = RGB1;
    frame_next    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (en) begin
          state_next = ST_PREFETCH;
          row_next   = '0;
          plane_next = '0;
          col_next   = '0;
          ph_next    = 1'b0;
        end
      end
      ST_PREFETCH: state_next = ST_SHIFT;
      ST_SHIFT: begin
        // Data lands while LP_CLK is low; the clock rises a cycle later on stable data.
        if (!ph_reg) begin
          {rgb1_next, rgb0_next} = fb_rd_data;
          ph_next = 1'b1;
          if (col_reg != LAST_COL) begin
            rd_en_next  = 1'b1;
            fb_col_next = col_reg + 1'b1;
          end
        end else begin
          lp_next = 1'b1;
          ph_next = 1'b0;
          if (col_reg == LAST_COL) begin
            state_next = ST_BLANK;
            col_next   = '0;
          end else begin
            col_next = col_reg + 1'b1;
          end
        end
      end
      ST_BLANK: state_next = ST_LATCH;
      ST_LATCH: begin
        latch_next   = 1'b1;
        row_out_next = row_reg;
        timer_load   = 1'b1;
        state_next   = ST_DISPLAY;
      end
      ST_DISPLAY: begin
        noe_next = ~timer_on;
        if (timer_done) begin
          if (plane_reg == LAST_PLANE) begin
            plane_next = '0;
            row_next   = row_reg + 1'b1;
            frame_next = (row_reg == '1);
          end else begin
            plane_next = plane_reg + 1'b1;
          end
          col_next   = '0;
          ph_next    = 1'b0;
          state_next = en ? ST_PREFETCH : ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Column 0 is requested on PREFETCH entry so its data is ready for the first shift phase.
    if (state_next == ST_PREFETCH) begin
      rd_en_next    = 1'b1;
      fb_col_next   = '0;
      fb_row_next   = row_next;
      fb_plane_next = plane_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      row_reg    <= '0;
      plane_reg  <= '0;
      col_reg    <= '0;
      ph_reg     <= 1'b0;
      fb_rd_en   <= 1'b0;
      fb_row     <= '0;
      fb_col     <= '0;
      fb_plane   <= '0;
      LP_CLK     <= 1'b0;
      LATCH      <= 1'b0;
      NOE        <= 1'b1;
      ROW        <= '0;
      RGB0       <= '0;
      RGB1       <= '0;
      frame_done <= 1'b0;
    end else begin
      state_reg  <= state_next;
      row_reg    <= row_next;
      plane_reg  <= plane_next;
      col_reg    <= col_next;
      ph_reg     <= ph_next;
      fb_rd_en   <= rd_en_next;
      fb_row     <= fb_row_next;
      fb_col     <= fb_col_next;
      fb_plane   <= fb_plane_next;
      LP_CLK     <= lp_next;
      LATCH      <= latch_next;
      NOE        <= noe_next;
      ROW        <= row_out_next;
      RGB0       <= rgb0_next;
      RGB1       <= rgb1_next;
      frame_done <= frame_next;
    end
  end

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Scoreboard bench for hub75_scan_ctrl: random framebuffer, expected panel events queued per row-plane.
module tb_hub75_scan_ctrl;
  import hub75_pkg::*;

  localparam int COLS = 64;
  localparam int ROWS = 32;
  localparam int BCM  = 3;
  localparam int BASE = 8;
  localparam int RP_RUN1 = ROWS * BCM + 5 * BCM + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       fb_rd_en;
  logic [4:0] fb_row;
  logic [5:0] fb_col;
  logic [1:0] fb_plane;
  logic [5:0] fb_rd_data = '0;
  logic       LP_CLK, LATCH, NOE, frame_done;
  logic [4:0] ROW;
  logic [2:0] RGB0, RGB1;
`ifdef HUB75_BRIGHTNESS_EN
  logic [3:0] brightness = 4'd15;
`endif

  hub75_scan_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
`ifdef HUB75_BRIGHTNESS_EN
    .brightness (brightness),
`endif
    .fb_rd_en   (fb_rd_en),
    .fb_row     (fb_row),
    .fb_col     (fb_col),
    .fb_plane   (fb_plane),
    .fb_rd_data (fb_rd_data),
    .LP_CLK     (LP_CLK),
    .LATCH      (LATCH),
    .NOE        (NOE),
    .ROW        (ROW),
    .RGB0       (RGB0),
    .RGB1       (RGB1),
    .frame_done (frame_done)
  );

  always #20 clk = ~clk;

  // Framebuffer with one cycle of read latency.
  logic [5:0] fb_mem [ROWS][COLS][BCM];
  always @(posedge clk) if (fb_rd_en) fb_rd_data <= fb_mem[fb_row][fb_col][fb_plane];

  typedef enum int {EV_PIX, EV_LATCH, EV_FRAME, EV_NOE} ev_kind_t;
  typedef struct { ev_kind_t kind; int val; } ev_t;
  ev_t sb[$];

  int checks = 0;
  int errors = 0;
  int noe_pops = 0;
  int lp_rises = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  // Row-plane i of a run starting at row 0 plane 0: planes cycle fastest, rows wrap at ROWS.
  task automatic push_rowplanes(input int count);
    int r, p;
    for (int i = 0; i < count; i++) begin
      r = (i / BCM) % ROWS;
      p = i % BCM;
      for (int c = 0; c < COLS; c++) sb.push_back('{kind: EV_PIX, val: int'(fb_mem[r][c][p])});
      sb.push_back('{kind: EV_LATCH, val: r});
      if (p == BCM - 1 && r == ROWS - 1) sb.push_back('{kind: EV_FRAME, val: 1});
      sb.push_back('{kind: EV_NOE, val: BASE << p});
    end
  endtask

  task automatic expect_ev(input ev_kind_t k, input int v);
    ev_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected event value %0d, required no event", k.name(), v);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || e.val != v) begin
        errors++;
        $display("FAIL %s: got %s %0d, required %s %0d", k.name(), k.name(), v, e.kind.name(), e.val);
      end
    end
  endtask

  // Monitor: turns panel pin activity into events and checks them against the queue.
  logic       lp_q = 1'b0;
  logic [5:0] rgb_q = '0;
  int         noe_low = 0;
  int         last_row = 0;
  always @(negedge clk) begin
    if (rst) begin
      lp_q = 1'b0;
      rgb_q = '0;
      noe_low = 0;
    end else begin
      if ({RGB1, RGB0} != rgb_q) begin
        checks++;
        if (LP_CLK) begin
          errors++;
          $display("FAIL rgb_order: data changed to %h while LP_CLK=1, required LP_CLK=0", {RGB1, RGB0});
        end
      end
      if (LP_CLK && !lp_q) begin
        lp_rises++;
        expect_ev(EV_PIX, int'({RGB1, RGB0}));
      end
      if (LATCH) begin
        last_row = int'(ROW);
        expect_ev(EV_LATCH, int'(ROW));
      end
      if (frame_done) expect_ev(EV_FRAME, 1);
      if (!NOE) noe_low++;
      else if (noe_low > 0) begin
        expect_ev(EV_NOE, noe_low);
        $display("row-plane done: row=%0d noe_low=%0d", last_row, noe_low);
        noe_pops++;
        noe_low = 0;
      end
      lp_q = LP_CLK;
      rgb_q = {RGB1, RGB0};
    end
  end

  initial begin
    int t, lp_snap, rd_seen, base;

    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        for (int p = 0; p < BCM; p++) fb_mem[r][c][p] = 6'($urandom);

    repeat (3) @(negedge clk);
    chk("rst_lp_clk", LP_CLK, 0);
    chk("rst_latch", LATCH, 0);
    chk("rst_noe", NOE, 1);
    chk("rst_row", ROW, 0);
    chk("rst_rgb", {RGB1, RGB0}, 0);
    chk("rst_rd_en", fb_rd_en, 0);
    chk("rst_frame_done", frame_done, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_noe", NOE, 1);
    chk("idle_rd_en", fb_rd_en, 0);

    // Run 1: one full frame plus rows 0..5 of the next, en dropped mid-shift of row 5 plane 1.
    push_rowplanes(RP_RUN1);
    en = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!fb_rd_en && t < 10);
    chk("prefetch_rd_en", fb_rd_en, 1);
    chk("prefetch_addr", {fb_row, fb_col, fb_plane}, 0);
    t = 0;
    do begin @(negedge clk); t++; end while (!LATCH && t < 200);
    chk("first_latch_cycle", t, 131);
    chk("lp_edges_before_latch", lp_rises, 64);
    do begin @(negedge clk); t++; end while (!frame_done && t < 20000);
    chk("frame_done_cycle", t, 14368);

    t = 0;
    do begin @(negedge clk); t++; end
    while (!(fb_rd_en && fb_row == 5 && fb_plane == 1 && fb_col == 20) && t < 3000);
    chk("reach_row5_plane1", int'(t < 3000), 1);
    en = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (noe_pops < RP_RUN1 && t < 1000);
    chk("drop_en_completes", noe_pops, RP_RUN1);
    lp_snap = lp_rises;
    rd_seen = 0;
    repeat (300) begin @(negedge clk); if (fb_rd_en) rd_seen++; end
    chk("idle_no_lp_edges", lp_rises - lp_snap, 0);
    chk("idle_no_reads", rd_seen, 0);
    chk("idle_noe_high", NOE, 1);
    chk("queue_drained", sb.size(), 0);

    // Run 2: restart from IDLE at row 0, reset asynchronously during DISPLAY of row 1 plane 1.
    base = noe_pops;
    push_rowplanes(5);
    en = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (noe_pops < base + 4 && t < 2000);
    chk("restart_rowplanes", noe_pops, base + 4);
    t = 0;
    do begin @(negedge clk); t++; end while (NOE && t < 400);
    repeat (5) @(negedge clk);
    chk("noe_low_before_rst", NOE, 0);
    chk("row_before_rst", ROW, 1);
    #5 rst = 1'b1;
    #1;
    chk("async_rst_noe", NOE, 1);
    chk("async_rst_row", ROW, 0);
    chk("async_rst_lp_latch", {LP_CLK, LATCH, fb_rd_en, frame_done}, 0);
    chk("async_rst_rgb", {RGB1, RGB0}, 0);
    sb.delete();

    // Run 3: after reset the scan starts again at row 0 plane 0.
    push_rowplanes(6);
    base = noe_pops;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!fb_rd_en && t < 10);
    chk("post_rst_prefetch_addr", {fb_row, fb_col, fb_plane}, 0);
    t = 0;
    do begin @(negedge clk); t++; end while (noe_pops < base + 4 && t < 2000);
    chk("post_rst_rowplanes", noe_pops, base + 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hub75_scan_ctrl.md
Name: hub75_scan_ctrl

Overview:
Scan sequencer for the 64x64 HUB75 LED matrix (1/32 scan, two half-panels driven via RGB0/RGB1).
- Reads pixel bit-planes from an external framebuffer with 1-cycle read latency.
- Drives shift clock, latch, blank and row select, with binary-coded-modulation (BCM) on-times per plane.
- Sits between the framebuffer/renderer (e.g. temperature display renderer) and the panel pins; it is the only block that touches LP_CLK/LATCH/NOE/ROW.

Parameters:
COLS, 64, columns shifted per row (power of two).
ROW_BITS, 5, row address width (rows = 2**ROW_BITS per half-panel).
BCM_BITS, 3, bit-planes per colour channel (1..8).
BASE_ON, 8, NOE-low cycles of plane 0; plane p is on for BASE_ON<<p cycles.

Ports:
clk  in  1  system clock (25 MHz)
rst  in  1  asynchronous, active-high reset
en  in  1  run enable
fb_rd_en  out  1  framebuffer read strobe
fb_row  out  ROW_BITS  framebuffer read row
fb_col  out  clog2(COLS)  framebuffer read column
fb_plane  out  clog2(BCM_BITS) (min 1)  framebuffer read bit-plane
fb_rd_data  in  6  {RGB1,RGB0} plane bits; valid the cycle after fb_rd_en
LP_CLK  out  1  panel shift clock
LATCH  out  1  panel latch
NOE  out  1  panel output enable, active low
ROW  out  ROW_BITS  panel row select
RGB0  out  3  upper half-panel data
RGB1  out  3  lower half-panel data
frame_done  out  1  one-cycle pulse at end of last row/last plane

Behaviour:
- Reset (asynchronous): state IDLE; counters zero; LP_CLK=0, LATCH=0, NOE=1, ROW=0, RGB0=RGB1=0, fb_rd_en=0, frame_done=0.
- All outputs are registered.
- States: IDLE, PREFETCH, SHIFT, BLANK, LATCH, DISPLAY.
- IDLE: NOE=1. When en=1, go to PREFETCH with row=0 and plane=0.
- PREFETCH (1 cycle): fb_rd_en=1 with fb_col=0 and the current row/plane.
- SHIFT (2*COLS cycles), one column per two cycles:
  - ph=0: RGB0/RGB1 <= fb_rd_data; LP_CLK=0.
  - ph=1: LP_CLK=1; fb_rd_en=1 for col+1 (no read on the last column).
  - After col=COLS-1 ph=1, go to BLANK.
- Ordering rule: data changes only while LP_CLK=0, and RGB is stable across each rising edge.
- BLANK (1 cycle): NOE=1, LP_CLK=0.
- LATCH (1 cycle): LATCH=1, NOE=1; ROW <= current row in this same cycle.
- DISPLAY: NOE=0 for exactly BASE_ON<<plane cycles, then NOE=1 and advance:
  - plane+1 if plane < BCM_BITS-1;
  - otherwise plane=0 and row+1;
  - on row wrap (2**ROW_BITS-1 -> 0), frame_done pulses for 1 cycle, coincident with the first cycle after DISPLAY.
  - Then go to PREFETCH if en=1, else IDLE.
- en is sampled only in IDLE and at the end of DISPLAY. Deasserting mid-row completes the current row-plane; the panel is never left latched mid-shift.
- Row-plane period = 3 + 2*COLS + (BASE_ON<<plane). Defaults give 139/147/163 cycles, 449 per row, 14368 per frame.
- Counters wrap modulo their widths; the DISPLAY counter is wide enough for BASE_ON<<(BCM_BITS-1).
- Reset mid-operation returns to IDLE immediately (NOE=1 asynchronously).

Optional Feature:
HUB75_BRIGHTNESS_EN:
- Adds input port `brightness[3:0]`, sampled at LATCH entry.
- During DISPLAY, a 4-bit pwm counter runs (cleared at DISPLAY entry, +1 per cycle, wraps).
- NOE=0 only while pwm_cnt <= brightness, within the same BASE_ON<<plane window.
- Result: brightness=15 gives full on-time; brightness=0 gives 1 of every 16 cycles.
- Without the macro: no port, and NOE=0 for the whole DISPLAY window.

Decomposition:
- hub75_pkg:
  - state enum (IDLE..DISPLAY);
  - widths COL_W=clog2(COLS), PLANE_W;
  - constant SHIFT_CYCLES=2*COLS;
  - function on_cycles(plane).
- Sub-module hub75_bcm_timer: loads BASE_ON<<plane, counts down, asserts done, and (under the macro) drives the pwm gating.

Test Plan:
- Reset, en=1, fb_rd_data=6'b000001 constant -> first LATCH pulse at cycle 131 after PREFETCH; 64 LP_CLK rising edges before it with RGB0=001; ROW=0.
- Full frame, defaults -> frame_done every 14368 cycles; ROW sweeps 0..31; NOE-low widths 8/16/32 per row in plane order.
- fb_rd_data = fb_col[5:0] pattern -> shifted RGB0/RGB1 sequence equals col-derived bits, confirming 1-cycle read-latency alignment.
- Drop en mid-SHIFT of row 5 plane 1 -> row 5 plane 1 completes (LATCH, 16-cycle NOE low), then IDLE with NOE=1; no further LP_CLK edges.
- Assert rst during DISPLAY -> NOE=1 the same cycle without a clock edge; all outputs at reset values; restart begins at row 0.
- With HUB75_BRIGHTNESS_EN, brightness=3, plane 2 -> NOE low for 8 of 32 cycles (pwm 0..3 in each of two 16-cycle windows).
